// File: rtl/fsm_pkg.sv
// Shared types and constants for the fsm read/delay/done sequencer.
package fsm_pkg;

    localparam int DLY_MAX = 16;
    localparam int CNT_W   = $clog2(DLY_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        DLY  = 2'b11,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fsm_if.sv
// Handshake bundle for the fsm sequencer; ws is only wired to the DUT when FSM_WS_EN is defined.
interface fsm_if;

    logic go;
    logic ws;
    logic rd;
    logic ds;

    modport master (output go, ws, input rd, ds);
    modport slave  (input go, ws, output rd, ds);

endinterface

// File: rtl/fsm_dly_cnt.sv
// Down-counter timing the DLY state: clear, load, decrement and a zero flag.
module fsm_dly_cnt
    import fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fsm.sv
// Moore sequencer IDLE -> READ -> DLY (DLY_CYCLES) -> DONE; define FSM_WS_EN to add the ws retry input.
module fsm
    import fsm_pkg::*;
#(
    parameter int DLY_CYCLES = 1
) (
    output logic ds,
    output logic rd,
    input  logic go,
    input  logic clk,
    input  logic rst
`ifdef FSM_WS_EN
    ,
    input  logic ws
`endif
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DLY_CYCLES - 1);

    state_t r_state;
    state_t w_next;
    logic   w_clr;
    logic   w_load;
    logic   w_dec;
    logic   w_zero;
    logic   w_ws;

`ifdef FSM_WS_EN
    assign w_ws = ws;
`else
    assign w_ws = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_dec  = 1'b0;
        rd     = 1'b0;
        ds     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (go) w_next = READ;
            end
            READ: begin
                rd     = 1'b1;
                w_load = 1'b1;
                w_next = DLY;
            end
            DLY: begin
                rd = 1'b1;
                // A retry request restarts the read and re-arms the delay.
                if (w_ws) begin
                    w_clr  = 1'b1;
                    w_next = READ;
                end else if (w_zero) begin
                    w_next = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                ds     = 1'b1;
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    fsm_dly_cnt u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (LOAD_VAL),
        .o_zero     (w_zero)
    );

endmodule

// File: tb/tb_fsm.sv
// Randomized self-checking bench for fsm against a cycle-phase reference model.
module tb_fsm;
    import fsm_pkg::*;

    localparam int D = 1;
    localparam int P = 3 + D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    fsm_if bus ();

    always #5 clk = ~clk;

    fsm #(.DLY_CYCLES(D)) dut (
        .ds  (bus.ds),
        .rd  (bus.rd),
        .go  (bus.go),
        .clk (clk),
        .rst (rst)
`ifdef FSM_WS_EN
        ,
        .ws  (bus.ws)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: -1 idle, otherwise cycles since the accepting edge (0 read, 1..D delay, D+1 done).
    int m_phase = -1;

    function automatic logic exp_rd();
        return (m_phase >= 0) && (m_phase <= D);
    endfunction

    function automatic logic exp_ds();
        return m_phase == D + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            m_phase = -1;
        end else if (m_phase < 0) begin
            if (bus.go) m_phase = 0;
        end else if (bus.ws && m_phase >= 1 && m_phase <= D) begin
            m_phase = 0;
        end else if (m_phase >= D + 1) begin
            m_phase = -1;
        end else begin
            m_phase = m_phase + 1;
        end
        #1;
    endtask

    task automatic drain(input string name);
        bus.go = 1'b0;
        bus.ws = 1'b0;
        for (int i = 0; i < P; i++) begin
            step();
            n_tests++;
            if (bus.rd !== exp_rd() || bus.ds !== exp_ds()) begin
                n_fail++;
                $display("FAIL %s_drain cyc=%0d rd=%b ds=%b expected rd=%b ds=%b",
                         name, i, bus.rd, bus.ds, exp_rd(), exp_ds());
            end
        end
    endtask

    task automatic test_reset();
        bus.go = 1'b0;
        bus.ws = 1'b0;
        rst    = 1'b0;
        #1;
        n_tests++;
        if (bus.rd !== 1'b0 || bus.ds !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold rd=%b ds=%b expected rd=0 ds=0", bus.rd, bus.ds);
        end
        step();
        step();
        #3 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (bus.rd !== 1'b0 || bus.ds !== 1'b0 || dut.r_state !== IDLE) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d rd=%b ds=%b state=%b expected rd=0 ds=0 state=%b",
                         i, bus.rd, bus.ds, dut.r_state, IDLE);
            end
        end
    endtask

    task automatic test_single_pulse();
        bus.go = 1'b1;
        step();
        n_tests++;
        if (bus.rd !== 1'b1 || bus.ds !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_first rd=%b ds=%b expected rd=1 ds=0", bus.rd, bus.ds);
        end
        drain("pulse");
    endtask

    task automatic test_held_go();
        int ds_cnt = 0;
        int rd_cnt = 0;
        bus.go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            ds_cnt += int'(bus.ds);
            rd_cnt += int'(bus.rd);
            n_tests++;
            if (bus.rd !== exp_rd() || bus.ds !== exp_ds()) begin
                n_fail++;
                $display("FAIL held cyc=%0d rd=%b ds=%b expected rd=%b ds=%b",
                         i, bus.rd, bus.ds, exp_rd(), exp_ds());
            end
        end
        n_tests++;
        if (ds_cnt != 13 / P || rd_cnt != (D + 1) * (13 / P)) begin
            n_fail++;
            $display("FAIL held_counts ds_pulses=%0d rd_cycles=%0d expected ds_pulses=%0d rd_cycles=%0d",
                     ds_cnt, rd_cnt, 13 / P, (D + 1) * (13 / P));
        end
        drain("held");
    endtask

    task automatic test_go_pattern();
        logic [9:0] pat = 10'b1101101011;
        for (int i = 0; i < 10; i++) begin
            bus.go = pat[9 - i];
            step();
            n_tests++;
            if (bus.rd !== exp_rd() || bus.ds !== exp_ds()) begin
                n_fail++;
                $display("FAIL pattern cyc=%0d rd=%b ds=%b expected rd=%b ds=%b",
                         i, bus.rd, bus.ds, exp_rd(), exp_ds());
            end
        end
        drain("pattern");
    endtask

    task automatic test_async_reset();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        #3 rst = 1'b0;
        m_phase = -1;
        #1;
        n_tests++;
        if (bus.rd !== 1'b0 || bus.ds !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset rd=%b ds=%b expected rd=0 ds=0", bus.rd, bus.ds);
        end
        step();
        step();
        #3 rst = 1'b1;
        drain("abort");
        test_single_pulse();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            bus.go = 1'($urandom_range(0, 1));
`ifdef FSM_WS_EN
            bus.ws = ($urandom_range(0, 3) == 0);
`endif
            step();
            n_tests++;
            if (bus.rd !== exp_rd() || bus.ds !== exp_ds()) begin
                n_fail++;
                $display("FAIL random cyc=%0d rd=%b ds=%b expected rd=%b ds=%b",
                         i, bus.rd, bus.ds, exp_rd(), exp_ds());
            end
        end
        drain("random");
    endtask

`ifdef FSM_WS_EN
    task automatic test_ws();
        int visits = 0;
        int ds_cnt = 0;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < 4 * P; i++) begin
            bus.ws = (m_phase >= 1 && m_phase <= D && visits < 2);
            if (bus.ws) visits++;
            step();
            ds_cnt += int'(bus.ds);
            n_tests++;
            if (bus.rd !== exp_rd() || bus.ds !== exp_ds()) begin
                n_fail++;
                $display("FAIL ws cyc=%0d rd=%b ds=%b expected rd=%b ds=%b",
                         i, bus.rd, bus.ds, exp_rd(), exp_ds());
            end
        end
        n_tests++;
        if (ds_cnt != 1) begin
            n_fail++;
            $display("FAIL ws_ds_count got=%0d expected=1", ds_cnt);
        end
    endtask
`endif

    initial begin
        bus.go = 1'b0;
        bus.ws = 1'b0;
        test_reset();
        test_single_pulse();
        test_held_go();
        test_go_pattern();
        test_async_reset();
`ifdef FSM_WS_EN
        test_ws();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
